instruction_decode_stage: RTL and testbench

- Consumer end of the fetch-to-decode interface. Accepts the `{pc, instruction}` pair the fetch stage presents each cycle and decodes the 16-bit instruction.
- Reads operands from an internal 8x16 register file. The register file is written by the write-back port.
- Registers a decoded bundle for the execute stage.
- Detects load-use hazards and halts, and back-pressures fetch via `stall`.

---
 rtl/instruction_decode_stage.sv | 172 +++++++++++++++++
 tb/tb_instruction_decode_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode_stage.sv
// Decode stage: accepts {pc, instruction} from fetch, reads an 8x16 register
// file, registers a decoded bundle for execute, and stalls fetch on load-use
// hazards or after HALT.
// Optional macro: ID_WB_BYPASS_EN forwards same-cycle write-back data to operands.
module instruction_decode_stage #(
  parameter int unsigned PC_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [PC_WIDTH-1:0]   if_pc,
  input  logic [15:0]           if_instruction,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [2:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  stall,
  output logic                  halted,
  output logic                  id_valid,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [3:0]            id_opcode,
  output logic [2:0]            id_rd,
  output logic [DATA_WIDTH-1:0] id_rs1_data,
  output logic [DATA_WIDTH-1:0] id_rs2_data,
  output logic [DATA_WIDTH-1:0] id_imm,
  output logic                  id_reg_write,
  output logic                  id_mem_read,
  output logic                  id_mem_write,
  output logic                  id_branch
);

  localparam int unsigned IMM_W = 6;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {RUN, HALTED} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  id_valid_q, id_valid_d;
  logic [PC_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [3:0]            id_opcode_q, id_opcode_d;
  logic [2:0]            id_rd_q, id_rd_d;
  logic [DATA_WIDTH-1:0] id_rs1_data_q, id_rs1_data_d;
  logic [DATA_WIDTH-1:0] id_rs2_data_q, id_rs2_data_d;
  logic [DATA_WIDTH-1:0] id_imm_q, id_imm_d;
  logic                  id_reg_write_q, id_reg_write_d;
  logic                  id_mem_read_q, id_mem_read_d;
  logic                  id_mem_write_q, id_mem_write_d;
  logic                  id_branch_q, id_branch_d;

  // Field extraction and source usage of the instruction presented by fetch
  logic [3:0] op;
  logic [2:0] rd_f, rs1_f, src2_f;
  logic       uses_rs1, uses_src2, src2_alt, hazard, accept;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

  always_comb begin
    op        = if_instruction[15:12];
    rd_f      = if_instruction[11:9];
    rs1_f     = if_instruction[8:6];
    src2_alt  = (op == OP_ST) || (op == OP_BEQ);
    src2_f    = src2_alt ? rd_f : if_instruction[5:3];
    uses_rs1  = (op >= OP_ADD) && (op <= OP_BEQ);
    uses_src2 = ((op >= OP_ADD) && (op <= OP_OR)) || src2_alt;

    rs1_val = regs_q[rs1_f];
    rs2_val = regs_q[src2_f];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_rd != 3'd0) && (wb_rd == rs1_f))  rs1_val = wb_data;
    if (wb_en && (wb_rd != 3'd0) && (wb_rd == src2_f)) rs2_val = wb_data;
`endif

    hazard = id_valid_q && id_mem_read_q && (id_rd_q != 3'd0) && if_valid &&
             ((uses_rs1 && (rs1_f == id_rd_q)) || (uses_src2 && (src2_f == id_rd_q)));
    stall  = (state_q == HALTED) || (hazard && !flush);
    accept = if_valid && !stall && !flush && (state_q == RUN);
    halted = (state_q == HALTED);
  end

  // Register file next state; R0 is never written so it always reads zero
  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_rd != 3'd0)) regs_d[wb_rd] = wb_data;
  end

  // Next state and decoded bundle; non-accepted cycles hold payload, clear flags
  always_comb begin
    state_d        = state_q;
    id_valid_d     = 1'b0;
    id_pc_d        = id_pc_q;
    id_opcode_d    = id_opcode_q;
    id_rd_d        = id_rd_q;
    id_rs1_data_d  = id_rs1_data_q;
    id_rs2_data_d  = id_rs2_data_q;
    id_imm_d       = id_imm_q;
    id_reg_write_d = 1'b0;
    id_mem_read_d  = 1'b0;
    id_mem_write_d = 1'b0;
    id_branch_d    = 1'b0;
    if (accept) begin
      id_valid_d     = 1'b1;
      id_pc_d        = if_pc;
      id_opcode_d    = op;
      id_rd_d        = rd_f;
      id_rs1_data_d  = rs1_val;
      id_rs2_data_d  = rs2_val;
      id_imm_d       = {{(DATA_WIDTH-IMM_W){if_instruction[IMM_W-1]}}, if_instruction[IMM_W-1:0]};
      id_reg_write_d = (op >= OP_ADD) && (op <= OP_LD) && (rd_f != 3'd0);
      id_mem_read_d  = (op == OP_LD);
      id_mem_write_d = (op == OP_ST);
      id_branch_d    = (op == OP_BEQ);
      if (op == OP_HALT) state_d = HALTED;
    end
  end

  // State, register file and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      id_valid_q     <= 1'b0;
      id_pc_q        <= '0;
      id_opcode_q    <= '0;
      id_rd_q        <= '0;
      id_rs1_data_q  <= '0;
      id_rs2_data_q  <= '0;
      id_imm_q       <= '0;
      id_reg_write_q <= 1'b0;
      id_mem_read_q  <= 1'b0;
      id_mem_write_q <= 1'b0;
      id_branch_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      regs_q         <= regs_d;
      id_valid_q     <= id_valid_d;
      id_pc_q        <= id_pc_d;
      id_opcode_q    <= id_opcode_d;
      id_rd_q        <= id_rd_d;
      id_rs1_data_q  <= id_rs1_data_d;
      id_rs2_data_q  <= id_rs2_data_d;
      id_imm_q       <= id_imm_d;
      id_reg_write_q <= id_reg_write_d;
      id_mem_read_q  <= id_mem_read_d;
      id_mem_write_q <= id_mem_write_d;
      id_branch_q    <= id_branch_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_opcode    = id_opcode_q;
  assign id_rd        = id_rd_q;
  assign id_rs1_data  = id_rs1_data_q;
  assign id_rs2_data  = id_rs2_data_q;
  assign id_imm       = id_imm_q;
  assign id_reg_write = id_reg_write_q;
  assign id_mem_read  = id_mem_read_q;
  assign id_mem_write = id_mem_write_q;
  assign id_branch    = id_branch_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage; expected values hand-derived
// from the instruction encodings.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [2:0]  if_pc;
  logic [15:0] if_instruction;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        stall, halted, id_valid;
  logic [2:0]  id_pc;
  logic [3:0]  id_opcode;
  logic [2:0]  id_rd;
  logic [15:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_decode_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .if_instruction(if_instruction), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .halted(halted),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] pc, input logic [15:0] ins, input logic fl);
    if_valid = v; if_pc = pc; if_instruction = ins; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {reg_write, mem_read, mem_write, branch}
  function automatic logic [31:0] flags();
    return 32'({id_reg_write, id_mem_read, id_mem_write, id_branch});
  endfunction

  logic [15:0] byp_exp;

  initial begin
    reset = 1'b1; wb_en = 1'b0; wb_rd = 3'd0; wb_data = 16'h0;
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    #12;
    check_eq("rst_valid", 32'(id_valid), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_flags", flags(), 32'd0);
    reset = 1'b0;
    tick();

    // ADDI R1,R0,#-3 at pc 0
    drive(1'b1, 3'd0, 16'h523D, 1'b0);
    tick();
    check_eq("addi_valid", 32'(id_valid), 32'd1);
    check_eq("addi_pc", 32'(id_pc), 32'd0);
    check_eq("addi_rd", 32'(id_rd), 32'd1);
    check_eq("addi_imm", 32'(id_imm), 32'hFFFD);
    check_eq("addi_flags", flags(), 32'b1000);
    check_eq("addi_rs1", 32'(id_rs1_data), 32'd0);

    // Immediate sign-extension boundaries
    drive(1'b1, 3'd1, 16'h5220, 1'b0);
    tick();
    check_eq("imm_min", 32'(id_imm), 32'hFFE0);
    drive(1'b1, 3'd2, 16'h521F, 1'b0);
    tick();
    check_eq("imm_max", 32'(id_imm), 32'h001F);

    // Write R2 then ADD R3,R2,R2
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    wb_en = 1'b1; wb_rd = 3'd2; wb_data = 16'h1234;
    tick();
    wb_en = 1'b0;
    drive(1'b1, 3'd3, 16'h1690, 1'b0);
    tick();
    check_eq("add_rs1", 32'(id_rs1_data), 32'h1234);
    check_eq("add_rs2", 32'(id_rs2_data), 32'h1234);
    check_eq("add_pc", 32'(id_pc), 32'd3);

    // Same-cycle write of R6 with ADD R7,R6,R6
`ifdef ID_WB_BYPASS_EN
    byp_exp = 16'h5555;
`else
    byp_exp = 16'h0000;
`endif
    wb_en = 1'b1; wb_rd = 3'd6; wb_data = 16'h5555;
    drive(1'b1, 3'd4, 16'h1FB0, 1'b0);
    tick();
    wb_en = 1'b0;
    check_eq("byp_rs1", 32'(id_rs1_data), 32'(byp_exp));
    check_eq("byp_rs2", 32'(id_rs2_data), 32'(byp_exp));

    // Load-use: LD R4,[R1] then ADD R5,R4,R0
    drive(1'b1, 3'd0, 16'h6840, 1'b0);
    tick();
    check_eq("ld_flags", flags(), 32'b1100);
    check_eq("ld_rd", 32'(id_rd), 32'd4);
    drive(1'b1, 3'd1, 16'h1B00, 1'b0);
    #1;
    check_eq("lu_stall", 32'(stall), 32'd1);
    tick();
    check_eq("lu_bubble", 32'(id_valid), 32'd0);
    check_eq("lu_bubble_flags", flags(), 32'd0);
    check_eq("lu_stall_clear", 32'(stall), 32'd0);
    tick();
    check_eq("lu_add_valid", 32'(id_valid), 32'd1);
    check_eq("lu_add_rd", 32'(id_rd), 32'd5);
    check_eq("lu_add_pc", 32'(id_pc), 32'd1);

    // LD then independent ADD R5,R1,R0
    drive(1'b1, 3'd2, 16'h6840, 1'b0);
    tick();
    drive(1'b1, 3'd3, 16'h1A40, 1'b0);
    #1;
    check_eq("indep_stall", 32'(stall), 32'd0);
    tick();
    check_eq("indep_valid", 32'(id_valid), 32'd1);
    check_eq("indep_pc", 32'(id_pc), 32'd3);

    // LD then ST R4 (second source in [11:9]) must stall
    drive(1'b1, 3'd4, 16'h6840, 1'b0);
    tick();
    drive(1'b1, 3'd5, 16'h7800, 1'b0);
    #1;
    check_eq("st_hazard_stall", 32'(stall), 32'd1);
    // Flush in the stall cycle wins
    flush = 1'b1;
    #1;
    check_eq("flush_stall", 32'(stall), 32'd0);
    tick();
    check_eq("flush_valid", 32'(id_valid), 32'd0);
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    tick();

    // ST R2,[R1]: store data from R2
    drive(1'b1, 3'd6, 16'h7440, 1'b0);
    tick();
    check_eq("st_flags", flags(), 32'b0010);
    check_eq("st_data", 32'(id_rs2_data), 32'h1234);

    // BEQ R2,R2 -> branch, both operands R2
    drive(1'b1, 3'd7, 16'h8480, 1'b0);
    tick();
    check_eq("beq_flags", flags(), 32'b0001);
    check_eq("beq_rs2", 32'(id_rs2_data), 32'h1234);

    // Unused opcode decodes as valid NOP
    drive(1'b1, 3'd1, 16'hA123, 1'b0);
    tick();
    check_eq("undef_valid", 32'(id_valid), 32'd1);
    check_eq("undef_flags", flags(), 32'd0);

    // ADD with rd=0 never writes
    drive(1'b1, 3'd2, 16'h1090, 1'b0);
    tick();
    check_eq("rd0_flags", flags(), 32'd0);

    // Write to R0 is ignored
    drive(1'b0, 3'd0, 16'h0, 1'b0);
    wb_en = 1'b1; wb_rd = 3'd0; wb_data = 16'hFFFF;
    tick();
    wb_en = 1'b0;
    drive(1'b1, 3'd3, 16'h1200, 1'b0);
    tick();
    check_eq("r0_rs1", 32'(id_rs1_data), 32'd0);
    check_eq("r0_rs2", 32'(id_rs2_data), 32'd0);

    // Flushed HALT does not halt
    drive(1'b1, 3'd4, 16'hF000, 1'b1);
    tick();
    check_eq("fhalt_valid", 32'(id_valid), 32'd0);
    check_eq("fhalt_halted", 32'(halted), 32'd0);

    // HALT accepted
    drive(1'b1, 3'd5, 16'hF000, 1'b0);
    tick();
    check_eq("halt_valid", 32'(id_valid), 32'd1);
    check_eq("halt_opcode", 32'(id_opcode), 32'hF);
    check_eq("halt_flags", flags(), 32'd0);
    check_eq("halt_halted", 32'(halted), 32'd1);
    drive(1'b1, 3'd6, 16'h523D, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("halted_state", {30'd0, halted, stall}, 32'b11);
      check_eq("halted_valid", 32'(id_valid), 32'd0);
    end

    // Asynchronous reset out of HALTED
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst2_halted", 32'(halted), 32'd0);
    check_eq("rst2_stall", 32'(stall), 32'd0);
    check_eq("rst2_valid", 32'(id_valid), 32'd0);
    check_eq("rst2_pc", 32'(id_pc), 32'd0);
    check_eq("rst2_op", 32'(id_opcode), 32'd0);
    check_eq("rst2_imm", 32'(id_imm), 32'd0);
    check_eq("rst2_data", {id_rs1_data, id_rs2_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_eq("run_after_rst", 32'(id_valid), 32'd1);
    check_eq("run_after_rst_imm", 32'(id_imm), 32'hFFFD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
